// File: rtl/ecpri_resp_tx_if.sv
// Packet-memory read port and byte stream toward the MAC; master drives reads and tx bytes.
// The slave side supplies read data one cycle after mem_rd_en and applies tx_ready backpressure.
interface ecpri_resp_tx_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;

    modport master (
        output mem_rd_en, mem_addr, tx_data, tx_valid, tx_last,
        input  mem_rd_data, tx_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, tx_data, tx_valid, tx_last,
        output mem_rd_data, tx_ready
    );
endinterface

// File: rtl/ecpri_resp_tx.sv
// eCPRI response serialiser: copied header (MACs swapped), generated eCPRI header, optional payload.
// First byte 3 cycles after the request, then 1 byte/cycle; a 2-entry prefetch buffer absorbs tx_ready stalls.
module ecpri_resp_tx #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 8,
    parameter int          HDR_LEN    = 42,
    parameter logic [7:0]  ECPRI_REV  = 8'h10,
    parameter logic [7:0]  MSG_TYPE   = 8'h04
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_read_resp,
    input  logic                  send_write_resp,
    input  logic [7:0]            resp_payload_len,
    input  logic [ADDR_WIDTH-1:0] resp_src_addr,
    input  logic [ADDR_WIDTH-1:0] hdr_base,
    ecpri_resp_tx_if.master       bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            drop_cnt
);

    typedef enum logic [2:0] {IDLE, HDR, ECPRI, PAYLOAD, DONE} state_t;

    state_t                         state_q, state_d;
    logic                           is_rd_q, is_rd_d;
    logic [7:0]                     len_q, len_d;
    logic [ADDR_WIDTH-1:0]          src_q, src_d;
    logic [ADDR_WIDTH-1:0]          base_q, base_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic                           iss_done_q, iss_done_d;
    logic                           p_vld_q, p_vld_d;
    logic                           p_mem_q, p_mem_d;
    logic                           p_last_q, p_last_d;
    logic [DATA_WIDTH-1:0]          p_dat_q, p_dat_d;
    logic [1:0][DATA_WIDTH-1:0]     buf_dat_q, buf_dat_d;
    logic [1:0]                     buf_last_q, buf_last_d;
    logic                           wr_ptr_q, wr_ptr_d;
    logic                           rd_ptr_q, rd_ptr_d;
    logic [1:0]                     fifo_cnt_q, fifo_cnt_d;
    logic [7:0]                     drop_q, drop_d;

    logic                  active, head_vld, head_last, pop, space_ok, issue, mem_issue;
    logic                  hdr_last, ecpri_last, pay_last, has_payload, req_any;
    logic [ADDR_WIDTH-1:0] hdr_addr, pay_addr;
    logic [15:0]           size_w;
    logic [7:0]            gen_byte;
    logic [1:0]            n_drop;
    logic [8:0]            drop_sum;

    assign active      = (state_q == HDR) || (state_q == ECPRI) || (state_q == PAYLOAD);
    assign head_vld    = (fifo_cnt_q != 2'd0);
    assign head_last   = buf_last_q[rd_ptr_q];
    assign pop         = head_vld && bus.tx_ready;
    // Bytes in flight from the read issued last cycle must be counted, or the buffer could overflow.
    assign space_ok    = (3'(fifo_cnt_q) + 3'(p_vld_q)) < (3'd2 + 3'(pop));
    assign issue       = active && !iss_done_q && space_ok;
    assign mem_issue   = issue && ((state_q == HDR) || (state_q == PAYLOAD));
    assign has_payload = is_rd_q && (len_q != 8'd0);
    assign hdr_last    = (cnt_q == 8'(HDR_LEN - 1));
    assign ecpri_last  = (cnt_q == 8'd4);
    assign pay_last    = (cnt_q == len_q - 8'd1);
    assign pay_addr    = src_q + ADDR_WIDTH'(cnt_q);
    assign req_any     = send_read_resp || send_write_resp;

    // Destination and source MAC fields trade places; the rest of the header is copied verbatim.
    always_comb begin
        hdr_addr = base_q + ADDR_WIDTH'(cnt_q);
        if (cnt_q < 8'd6) begin
            hdr_addr = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(6);
        end else if (cnt_q < 8'd12) begin
            hdr_addr = base_q + ADDR_WIDTH'(cnt_q) - ADDR_WIDTH'(6);
        end
    end

    always_comb begin
        size_w = is_rd_q ? (16'(len_q) + 16'd1) : 16'd1;
        case (cnt_q[2:0])
            3'd0:    gen_byte = ECPRI_REV;
            3'd1:    gen_byte = MSG_TYPE;
            3'd2:    gen_byte = size_w[15:8];
            3'd3:    gen_byte = size_w[7:0];
            default: gen_byte = is_rd_q ? 8'h02 : 8'h03;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = HDR;
            HDR:     if (issue && hdr_last) state_d = ECPRI;
            ECPRI:   if (issue && ecpri_last && has_payload) state_d = PAYLOAD;
            PAYLOAD: state_d = PAYLOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (active && pop && head_last) state_d = DONE;
    end

    always_comb begin
        bus.mem_rd_en = mem_issue;
        bus.mem_addr  = '0;
        if (mem_issue) bus.mem_addr = (state_q == HDR) ? hdr_addr : pay_addr;
        bus.tx_valid  = head_vld;
        bus.tx_data   = buf_dat_q[rd_ptr_q];
        bus.tx_last   = head_last && head_vld;
        busy          = active;
        frame_done    = (state_q == DONE);
        drop_cnt      = drop_q;
    end

    always_comb begin
        is_rd_d    = is_rd_q;
        len_d      = len_q;
        src_d      = src_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        iss_done_d = iss_done_q;
        p_vld_d    = 1'b0;
        p_mem_d    = p_mem_q;
        p_last_d   = p_last_q;
        p_dat_d    = p_dat_q;
        buf_dat_d  = buf_dat_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (state_q == IDLE && req_any) begin
            is_rd_d    = send_read_resp;
            len_d      = resp_payload_len;
            src_d      = resp_src_addr;
            base_d     = hdr_base;
            cnt_d      = 8'd0;
            iss_done_d = 1'b0;
        end

        if (issue) begin
            p_vld_d  = 1'b1;
            p_mem_d  = mem_issue;
            p_dat_d  = DATA_WIDTH'(gen_byte);
            p_last_d = ((state_q == ECPRI) && ecpri_last && !has_payload) ||
                       ((state_q == PAYLOAD) && pay_last);
            cnt_d    = cnt_q + 8'd1;
            if (state_q == HDR && hdr_last) cnt_d = 8'd0;
            if (state_q == ECPRI && ecpri_last) begin
                cnt_d = 8'd0;
                if (!has_payload) iss_done_d = 1'b1;
            end
            if (state_q == PAYLOAD && pay_last) iss_done_d = 1'b1;
        end

        if (p_vld_q) begin
            buf_dat_d[wr_ptr_q]  = p_mem_q ? bus.mem_rd_data : p_dat_q;
            buf_last_d[wr_ptr_q] = p_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + 2'(p_vld_q) - 2'(pop);

        // A simultaneous read+write in IDLE costs one drop; outside IDLE every pulse is a drop.
        if (state_q == IDLE) n_drop = {1'b0, send_read_resp && send_write_resp};
        else                 n_drop = 2'(send_read_resp) + 2'(send_write_resp);
        drop_sum = 9'(drop_q) + 9'(n_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_rd_q    <= 1'b0;
            len_q      <= '0;
            src_q      <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            iss_done_q <= 1'b0;
            p_vld_q    <= 1'b0;
            p_mem_q    <= 1'b0;
            p_last_q   <= 1'b0;
            p_dat_q    <= '0;
            buf_dat_q  <= '0;
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
            drop_q     <= '0;
        end else begin
            is_rd_q    <= is_rd_d;
            len_q      <= len_d;
            src_q      <= src_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            iss_done_q <= iss_done_d;
            p_vld_q    <= p_vld_d;
            p_mem_q    <= p_mem_d;
            p_last_q   <= p_last_d;
            p_dat_q    <= p_dat_d;
            buf_dat_q  <= buf_dat_d;
            buf_last_q <= buf_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: doc/ecpri_resp_tx.md
Name: ecpri_resp_tx

Overview:
Downstream stage of the eCPRI receive handler. It consumes the single-cycle response requests (read or write response plus payload length) and serialises a complete response frame onto a byte stream toward the MAC. The Ethernet/IP/UDP header is copied from the received frame in packet memory, with MAC addresses swapped. The block then appends a generated eCPRI header and, for read responses, the payload read from packet memory.

Parameters:
ADDR_WIDTH, 16, packet memory address width
DATA_WIDTH, 8, byte width (only 8 supported)
HDR_LEN, 42, bytes of Eth+IP+UDP header copied from received frame
ECPRI_REV, 8'h10, eCPRI revision byte (first eCPRI header byte)
MSG_TYPE, 8'h04, eCPRI message type (remote memory access)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
send_read_resp  in  1  one-cycle pulse: build read response
send_write_resp  in  1  one-cycle pulse: build write response
resp_payload_len  in  8  read payload byte count N (ignored for write)
resp_src_addr  in  ADDR_WIDTH  packet-memory address of first read payload byte
hdr_base  in  ADDR_WIDTH  packet-memory address of byte 0 of received frame
mem_rd_en  out  1  packet memory read strobe
mem_addr  out  ADDR_WIDTH  packet memory read address
mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
tx_data  out  DATA_WIDTH  output byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte when tx_valid and tx_ready
tx_last  out  1  marks final byte of frame (qualified by tx_valid)
busy  out  1  high from request acceptance until final byte accepted
frame_done  out  1  one-cycle pulse the cycle after final byte accepted
drop_cnt  out  8  saturating count of rejected requests

Behaviour:
- Reset: all outputs 0, state IDLE, drop_cnt 0. Reset mid-frame aborts immediately; no partial-frame recovery and no frame_done.
- States: IDLE -> HDR -> ECPRI -> PAYLOAD (read only, N>0) -> DONE -> IDLE.
- IDLE: on a request pulse, latch type, N, resp_src_addr and hdr_base; set busy next cycle; go to HDR.
- Both pulses in the same cycle: read wins; write is dropped and drop_cnt += 1.
- Any request while busy=1 or in DONE: dropped, drop_cnt += 1 (+2 if both pulses). drop_cnt saturates at 255.
- HDR emits HDR_LEN bytes. Output byte i is read from:
  - i=0..5: hdr_base+6+i
  - i=6..11: hdr_base+i-6
  - i=12..41: hdr_base+i
- ECPRI emits 5 generated bytes, no memory reads:
  - ECPRI_REV
  - MSG_TYPE
  - size[15:8]
  - size[7:0]
  - status byte: 8'h02 for read response, 8'h03 for write response
  - size = 1+N for read, 1 for write (16-bit).
- PAYLOAD emits N bytes read from resp_src_addr+k, k=0..N-1. Skipped when N=0 or type is write.
- Frame length: HDR_LEN+5+N for read, HDR_LEN+5 for write. tx_last is asserted on the final byte only.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap from 16'hFFFF to 0 is legal.
- Stream rules:
  - Once tx_valid is high, tx_data and tx_last stay stable until accepted.
  - tx_valid never deasserts without acceptance except on reset.
  - No bytes dropped or duplicated under arbitrary tx_ready patterns.
  - Internal prefetch buffering (max 2 bytes) hides the 1-cycle memory latency.
  - With tx_ready held high, sustained throughput is 1 byte/cycle after the first byte.
- Latency: first tx_valid no later than 3 cycles after the request pulse.
- mem_rd_en is issued only when buffer space exists; no reads are issued in ECPRI, DONE or IDLE.
- DONE: frame_done=1 for exactly one cycle, busy falls in the same cycle, then return to IDLE. A new request is accepted from the cycle after DONE.

Test Plan:
- Write response: hdr_base=16'h0100, memory bytes 0x100..0x129 = 0x00..0x29, tx_ready=1 -> 47 bytes out. First 12 bytes are 06..0B,00..05, then 0C..29, then 10 04 00 01 03; tx_last on byte 47; frame_done 1 cycle later.
- Read response: N=4, resp_src_addr=16'h0200, data AA BB CC DD -> 51 bytes. eCPRI bytes 10 04 00 05 02, payload AA BB CC DD, tx_last on DD.
- Backpressure: read N=8 with tx_ready toggling 1,0,0,1 repeating -> byte sequence identical to the tx_ready=1 run; tx_data stable during stalls.
- Collisions: read and write pulsed in the same cycle -> read frame produced, drop_cnt=1. Three further pulses mid-frame -> drop_cnt=4, frame unchanged. 300 drops total -> drop_cnt=255.
- Boundaries: read N=0 -> 47 bytes, size 00 01. resp_src_addr=16'hFFFE, N=4 -> reads from FFFE, FFFF, 0000, 0001.
- Reset asserted at byte 20 -> tx_valid, busy and mem_rd_en drop immediately, no frame_done. A new write request after reset -> a full, correct 47-byte frame.
